// File: rtl/calr_pkg.sv
// calr_pkg: shared state encoding, rice limit and cRiceParam adaptation rule for the CALR scheduler
package calr_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_e;
  localparam int MAX_RICE_DEF = 4;
  // abs_lvl is two bits wider than any value so base+value cannot overflow
  function automatic logic [3:0] rice_update(input logic [3:0] used, input logic [1:0] base,
                                             input logic [31:0] value, input logic [3:0] max_rice);
    logic [33:0] abs_lvl;
    logic [33:0] thr;
    logic [4:0] nxt;
    abs_lvl = {2'b00, value} + {32'd0, base};
    thr = 34'd3 << used;
    nxt = {1'b0, used} + {4'd0, abs_lvl > thr};
    return (nxt > {1'b0, max_rice}) ? max_rice : nxt[3:0];
  endfunction
endpackage

// File: rtl/calr_rice_sched.sv
// calr_rice_sched: single-in-flight sequencer feeding the CALR binarization engine with adaptive cRiceParam
// Optional watchdog on the engine done wait: define CALR_SCHED_TIMEOUT_EN.
module calr_rice_sched
  import calr_pkg::*;
#(
  parameter int VALUE_WIDTH    = 16,
  parameter int BIN_WIDTH      = 16,
  parameter int MAX_RICE       = MAX_RICE_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VALUE_WIDTH-1:0] in_value,
  input  logic [1:0]             in_base_level,
  input  logic                   in_sb_first,
  output logic                   eng_start,
  output logic [VALUE_WIDTH-1:0] eng_value,
  output logic [3:0]             eng_rice,
  input  logic                   eng_done,
  input  logic [BIN_WIDTH-1:0]   eng_bins,
  input  logic [BIN_WIDTH-1:0]   eng_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIN_WIDTH-1:0]   out_bins,
  output logic [BIN_WIDTH-1:0]   out_len,
  output logic [3:0]             out_rice,
`ifdef CALR_SCHED_TIMEOUT_EN
  output logic                   err,
`endif
  output logic                   busy
);
  state_e                 state_q;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [1:0]             base_q;
  logic [3:0]             eng_rice_q, rice_q, rice_d, out_rice_q;
  logic [BIN_WIDTH-1:0]   out_bins_q, out_len_q;
`ifdef CALR_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign err = err_q;
`endif
  assign rice_d = rice_update(eng_rice_q, base_q, 32'(value_q), 4'(MAX_RICE));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      value_q    <= '0;
      base_q     <= '0;
      eng_rice_q <= '0;
      rice_q     <= '0;
      out_rice_q <= '0;
      out_bins_q <= '0;
      out_len_q  <= '0;
`ifdef CALR_SCHED_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          value_q    <= in_value;
          base_q     <= in_base_level;
          eng_rice_q <= in_sb_first ? 4'd0 : rice_q;
          state_q    <= START;
        end
        START: begin
`ifdef CALR_SCHED_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= WAIT;
        end
        // done is only trusted here; in START it may still be left over from the previous run
        WAIT: if (eng_done) begin
          out_bins_q <= eng_bins;
          out_len_q  <= eng_len;
          out_rice_q <= eng_rice_q;
          rice_q     <= rice_d;
          state_q    <= OUT;
        end
`ifdef CALR_SCHED_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        default: if (out_ready) state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign eng_start = state_q == START;
  assign out_valid = state_q == OUT;
  assign busy      = state_q != IDLE;
  assign eng_value = value_q;
  assign eng_rice  = eng_rice_q;
  assign out_bins  = out_bins_q;
  assign out_len   = out_len_q;
  assign out_rice  = out_rice_q;
endmodule

// File: tb/tb_calr_rice_sched.sv
// tb_calr_rice_sched: directed self-checking bench with a sticky-done engine model of fixed latency
module tb_calr_rice_sched;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, in_sb_first = 1'b0, out_ready = 1'b0;
  logic [15:0] in_value = '0;
  logic [1:0]  in_base_level = 2'd1;
  logic        in_ready, eng_start, eng_done, out_valid, busy;
  logic [15:0] eng_value, eng_bins, eng_len, out_bins, out_len;
  logic [3:0]  eng_rice, out_rice;
`ifdef CALR_SCHED_TIMEOUT_EN
  logic        err;
`endif
  int          vecs = 0, errs = 0, starts = 0, ecnt = 0;
  logic        done_q = 1'b0, hang = 1'b0;

  calr_rice_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .in_base_level(in_base_level), .in_sb_first(in_sb_first), .eng_start(eng_start),
    .eng_value(eng_value), .eng_rice(eng_rice), .eng_done(eng_done), .eng_bins(eng_bins),
    .eng_len(eng_len), .out_valid(out_valid), .out_ready(out_ready), .out_bins(out_bins),
    .out_len(out_len), .out_rice(out_rice),
`ifdef CALR_SCHED_TIMEOUT_EN
    .err(err),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  // engine: bins = value ^ 4 ^ (rice << 12), len = value + 1; done sticky, cleared by start, set 3 cycles later
  assign eng_bins = eng_value ^ 16'h0004 ^ {eng_rice, 12'h000};
  assign eng_len  = eng_value + 16'd1;
  assign eng_done = done_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      ecnt   <= 0;
    end else if (eng_start) begin
      done_q <= 1'b0;
      ecnt   <= 3;
      starts <= starts + 1;
    end else if (ecnt > 0 && !hang) begin
      ecnt <= ecnt - 1;
      if (ecnt == 1) done_q <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [15:0] v, input logic [1:0] b, input logic first,
                     input logic [3:0] exp_rice, input int hold);
    int s0;
    logic [15:0] bins0;
    s0 = starts;
    @(negedge clk);
    in_value = v; in_base_level = b; in_sb_first = first; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_sb_first = 1'b0;
    chk("start_pulse", eng_start, 1);
    chk("ready_low", in_ready, 0);
    @(negedge clk);
    chk("start_once", eng_start, 0);
    chk("no_stale_capture", out_valid, 0);
    chk("eng_rice", eng_rice, exp_rice);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("out_rice", out_rice, exp_rice);
    chk("out_bins", out_bins, v ^ 16'h0004 ^ {exp_rice, 12'h000});
    chk("out_len", out_len, v + 16'd1);
    bins0 = out_bins;
    for (int i = 0; i < hold; i++) begin
      in_value = ~in_value; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_bins", out_bins, bins0);
      chk("bp_value", eng_value, v);
      chk("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("one_start", starts - s0, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_drop", out_valid, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_bins", out_bins, 0);
    @(negedge clk);
    rst = 1'b1;
    // basic run, then prove rice_q stayed 0 (abs 3 > 3 is false)
    run(16'd2, 2'd1, 1'b1, 4'd0, 0);
    chk("basic_bins", out_bins, 16'h0006);
    run(16'd1, 2'd1, 1'b0, 4'd0, 0);
    // adaptation: 0 -> 1 -> 2, then abs 1 vs 12 keeps it at 2
    run(16'd5, 2'd1, 1'b1, 4'd0, 0);
    run(16'd10, 2'd1, 1'b0, 4'd1, 0);
    run(16'd0, 2'd3, 1'b0, 4'd2, 0);
    run(16'd0, 2'd1, 1'b0, 4'd2, 0);
    // saturation at MAX_RICE
    run(16'd1000, 2'd1, 1'b1, 4'd0, 0);
    run(16'd1000, 2'd1, 1'b0, 4'd1, 0);
    run(16'd1000, 2'd1, 1'b0, 4'd2, 0);
    run(16'd1000, 2'd1, 1'b0, 4'd3, 0);
    run(16'd1000, 2'd1, 1'b0, 4'd4, 0);
    run(16'd1000, 2'd1, 1'b0, 4'd4, 0);
    run(16'd1000, 2'd1, 1'b0, 4'd4, 0);
    run(16'd1000, 2'd1, 1'b0, 4'd4, 5);
    // reset while the engine never finishes
    hang = 1'b1;
    @(negedge clk);
    in_value = 16'd7; in_base_level = 2'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("wait_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_start", eng_start, 0);
    @(negedge clk);
    rst = 1'b1; hang = 1'b0;
    run(16'd0, 2'd1, 1'b0, 4'd0, 0);
`ifdef CALR_SCHED_TIMEOUT_EN
    hang = 1'b1;
    @(negedge clk);
    in_value = 16'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (70) @(negedge clk);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_valid", out_valid, 0);
    hang = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/calr_rice_sched.md
Name: calr_rice_sched

Overview:
- Sequencer for the coeff_abs_level_remaining (CALR) binarization engine.
- Accepts a stream of remaining-level values over valid/ready, selects and adapts cRiceParam per HEVC rules, and pulses the engine's start. It then waits for the engine's sticky done and returns {bins, length, rice} downstream over valid/ready.
- Sits between the coefficient scan logic and the bin/CABAC stage.

Parameters:
- VALUE_WIDTH, 16, width of CALR value and engine value port.
- BIN_WIDTH, 16, width of bin string and bin length.
- MAX_RICE, 4, saturation value of cRiceParam.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input value valid.
- in_ready  out  1  scheduler can accept a value.
- in_value  in  VALUE_WIDTH  coeff_abs_level_remaining.
- in_base_level  in  2  baseLevel (1..3) for this coefficient.
- in_sb_first  in  1  first CALR of a 4x4 sub-block; forces rice 0.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_value  out  VALUE_WIDTH  registered value, held stable until output handshake.
- eng_rice  out  4  registered cRiceParam, held stable likewise.
- eng_done  in  1  engine done; sticky level, cleared by the engine on start.
- eng_bins  in  BIN_WIDTH  engine bin string (combinational from held inputs).
- eng_len  in  BIN_WIDTH  engine bin length.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_bins  out  BIN_WIDTH  captured bin string.
- out_len  out  BIN_WIDTH  captured length.
- out_rice  out  4  rice parameter used for this value.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, rice_q=0. All outputs 0 except in_ready=1.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture value/base and set eng_rice = in_sb_first ? 0 : rice_q, then go to START.
  - START: eng_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: sample eng_done only here. eng_done is never sampled in START, because a stale done from the previous run may still be high. On eng_done=1, register eng_bins/eng_len/eng_rice into the out_* outputs, update rice_q, and go to OUT.
  - OUT: out_valid=1. out_* are stable until out_ready. On out_ready go to IDLE with out_valid=0 the next cycle.
- in_ready=0 in START/WAIT/OUT. Single value in flight; no overlap.
- eng_value/eng_rice are held constant from capture until OUT completes, because the engine datapath is combinational on them.
- Rice update:
  - used = eng_rice.
  - absLvl = base + value, computed in VALUE_WIDTH+2 bits with no overflow.
  - rice_q_next = min(used + (absLvl > 3<<used ? 1 : 0), MAX_RICE).
- Minimum latency: acceptance edge to out_valid = 3 cycles + engine latency.
- in_sb_first resets adaptation for that value only; its update still applies to rice_q.
- Reset mid-operation: immediate return to IDLE. eng_start deasserts asynchronously; the engine is reset by the same rst.
- eng_done arriving in OUT or IDLE is ignored.

Optional Feature:
- Macro: CALR_SCHED_TIMEOUT_EN.
- Defined:
  - Adds a counter cleared on entry to WAIT.
  - If eng_done is not seen within TIMEOUT_CYCLES, assert output err (1 bit, sticky until reset) and return to IDLE with no output and no rice update.
- Undefined: no counter, no err port; WAIT is unbounded.

Decomposition:
- calr_pkg:
  - state enum (IDLE, START, WAIT, OUT).
  - MAX_RICE_DEF constant.
  - rice_update function (used, base, value -> next).
- Natural sub-module: none required. The rice adapter may optionally be split as calr_rice_adapt (combinational) for unit test.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: rst low for 1 cycle while in WAIT.
  - Response: busy=0, in_ready=1, rice_q=0; the next value uses rice 0.
- Basic run:
  - Stimulus: sb_first=1, value=2, base=1, engine model returns bins=3'b110, len=3.
  - Response: eng_start is one pulse; out_bins=0x0006, out_len=3, out_rice=0; rice_q stays 0 (3 > 3 false).
- Adaptation sequence:
  - Stimulus: (5,b1,first), (10,b1), (0,b3).
  - Response: out_rice 0, 1, 2; rice_q ends at 2.
- Saturation:
  - Stimulus: eight values of 1000 with base=1 after sb_first.
  - Response: out_rice 0,1,2,3,4,4,4,4.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in OUT, toggling in_value.
  - Response: out_* and eng_value stable, in_ready=0, no new eng_start.
- Stale done and timeout:
  - Stale done: keep eng_done high from the prior run until the start edge; no premature capture.
  - Timeout (with CALR_SCHED_TIMEOUT_EN): never assert done; err=1 at TIMEOUT_CYCLES, back in IDLE.
